// File: rtl/qpsk_rz_modulator.sv
// QPSK RZ line modulator: FIFO-fed 2-bit symbols become two quarter-period chips then a half-period of zero. Optional MOD_UNDERRUN_CNT_EN adds underrun_cnt/underrun_clr.
// Latency: a symbol accepted before the boundary cycle reaches dout starting at the next sym_cnt == 0.
// Backpressure: sym_ready drops while the FIFO is full; the sender holds sym_valid/sym_data until accepted.
module qpsk_rz_modulator #(
    parameter int FREQ_DIV   = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    sym_data,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    output logic                          clk_symbol,
    output logic                          dout,
    output logic                          tx_active,
`ifdef MOD_UNDERRUN_CNT_EN
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          underrun_clr,
    output logic [15:0]                   underrun_cnt
`else
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`endif
);
    localparam int CW = $clog2(FREQ_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [CW-1:0] sym_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [1:0]    fifo_mem [FIFO_DEPTH];
    logic [1:0]    cur_sym;
    logic [1:0]    head;
    logic [1:0]    sym_nxt;
    logic          boundary;
    logic          empty;
    logic          push;
    logic          pop;
    logic          dout_nxt;

    assign boundary   = (sym_cnt == CW'(FREQ_DIV - 1));
    assign cnt_nxt    = sym_cnt + CW'(1);
    assign empty      = (wr_ptr == rd_ptr);
    assign fifo_level = wr_ptr - rd_ptr;
    assign sym_ready  = (fifo_level != LW'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr[PW-1:0]];
    assign push       = sym_valid && sym_ready;
    assign pop        = boundary && !empty;

    // dout is registered, so it is computed from the count and symbol of the coming cycle.
    always_comb begin
        sym_nxt  = cur_sym;
        dout_nxt = 1'b0;
        if (boundary) begin
            sym_nxt = empty ? 2'b00 : head;
        end
        if (cnt_nxt < CW'(FREQ_DIV / 4)) begin
            dout_nxt = sym_nxt[1] ^ sym_nxt[0];
        end else if (cnt_nxt < CW'(FREQ_DIV / 2)) begin
            dout_nxt = sym_nxt[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt    <= '0;
            clk_symbol <= 1'b0;
            dout       <= 1'b0;
            cur_sym    <= 2'b00;
            tx_active  <= 1'b0;
        end else begin
            sym_cnt    <= cnt_nxt;
            clk_symbol <= (cnt_nxt == CW'(FREQ_DIV - 1));
            dout       <= dout_nxt;
            cur_sym    <= sym_nxt;
            if (boundary) begin
                tx_active <= !empty;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 2'b00;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[PW-1:0]] <= sym_data;
                wr_ptr                   <= wr_ptr + LW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
        end
    end

`ifdef MOD_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            underrun_cnt <= 16'h0000;
        end else if (underrun_clr) begin
            underrun_cnt <= 16'h0000;
        end else if (boundary && empty && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: doc/qpsk_rz_modulator.md
Name: qpsk_rz_modulator

Overview:
- Transmit-side stage that feeds the 2-bit return-to-zero symbol demodulator.
- Accepts 2-bit symbols over a valid/ready handshake into a small FIFO.
- Generates the shared one-cycle symbol strobe `clk_symbol` every FREQ_DIV clocks.
- Serialises each symbol onto the 1-bit line `dout` as two quarter-period chips followed by a half-period of zero.

Parameters:
- FREQ_DIV, 128, system clocks per symbol; power of two, >= 8.
- FIFO_DEPTH, 4, symbol FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sym_data  input  2  symbol to transmit.
- sym_valid  input  1  sym_data is valid this cycle.
- sym_ready  output  1  FIFO can accept a symbol; equals !full.
- clk_symbol  output  1  one-cycle symbol-boundary strobe, period FREQ_DIV.
- dout  output  1  serial line to the demodulator.
- tx_active  output  1  current symbol period carries a real FIFO symbol (not underrun idle).
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: clock is clk; reset is asynchronous, active-low. All flops are cleared on reset.
- Symbol counter:
  - sym_cnt, width $clog2(FREQ_DIV), free-runs 0..FREQ_DIV-1 and wraps to 0.
  - It never stalls, so clk_symbol is continuous even when idle.
- Symbol strobe:
  - clk_symbol is registered and high exactly during the cycle where sym_cnt == FREQ_DIV-1.
  - The downstream counter is therefore 0 in the cycle where sym_cnt == 0.
- Chip mapping, symbol -> (chipA, chipB):
  - 00 -> (0,0)
  - 01 -> (1,0)
  - 10 -> (1,1)
  - 11 -> (0,1)
- Line waveform within one symbol period, for sym_cnt == k:
  - 0 <= k < FREQ_DIV/4: dout = chipA.
  - FREQ_DIV/4 <= k < FREQ_DIV/2: dout = chipB.
  - k >= FREQ_DIV/2: dout = 0.
  - dout is a flop; its value in the cycle where sym_cnt == k is the value computed for k.
- Sampling points: downstream samples at FREQ_DIV/8 and 3*FREQ_DIV/8, i.e. the middle of chipA and of chipB.
- Symbol load:
  - In the cycle where sym_cnt == FREQ_DIV-1, the FIFO head is popped into cur_sym if FIFO is non-empty, and tx_active is set to 1 for the next period.
  - If FIFO is empty (underrun): cur_sym <= 00, tx_active <= 0, and the line is all-zero for that period.
  - An underrun period is indistinguishable on the line from symbol 00. Upstream must keep the FIFO fed.
- FIFO:
  - Synchronous, first-word-fall-through head; read/write pointers carry one extra wrap bit.
  - Push when sym_valid && sym_ready.
  - sym_ready = (fifo_level != FIFO_DEPTH), combinational from registered level.
  - Push and pop in the same cycle: level unchanged; both occur.
  - Push while full: ignored, since sym_ready = 0; upstream must hold sym_valid and sym_data stable until accepted.
  - Push on the same cycle as a pop while empty: the pop sees empty (underrun). The pushed symbol is stored and sent in the following period.
  - Pointer wrap at FIFO_DEPTH is via power-of-two truncation; full/empty come from the MSB/LSB pointer compare.
- Latency: a symbol pushed into an empty FIFO before the boundary cycle appears on dout starting at the next sym_cnt == 0.
- Reset values:
  - sym_cnt = 0, clk_symbol = 0, dout = 0.
  - cur_sym = 00, tx_active = 0, FIFO empty, fifo_level = 0, sym_ready = 1.
- Reset asserted mid-symbol: FIFO contents are discarded. After release, sym_cnt restarts at 0 with an underrun (zero) period.

Optional Feature:
- Macro: MOD_UNDERRUN_CNT_EN.
- When defined: adds output port underrun_cnt [15:0].
  - Increments in each boundary cycle that takes the underrun path.
  - Saturates at 16'hFFFF.
  - Clears on reset and when input underrun_clr (1-bit, synchronous) is high. Clear wins over a simultaneous increment.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, no input, FREQ_DIV=128 -> clk_symbol high every 128 clocks at sym_cnt=127; dout constant 0; tx_active 0; sym_ready 1.
- Push 01, 10, 11, 00 back-to-back -> the next four periods show dout:
  - symbol 01: high for cnt 0–31, low thereafter.
  - symbol 10: high for cnt 0–63.
  - symbol 11: high for cnt 32–63.
  - symbol 00: low throughout.
  - Demodulator output, one period behind, reads 01, 10, 11, 00.
- Hold sym_valid with FIFO_DEPTH=4 and no drain -> sym_ready drops after the 4th accept; the 5th symbol is held until the next boundary pop, then accepted; fifo_level sequence is 1,2,3,4,3,4.
- Push exactly on a boundary cycle with the FIFO empty -> that period is underrun (tx_active 0, dout 0); the symbol is sent the following period.
- Assert reset at sym_cnt=40 during symbol 10 with 2 queued -> dout goes to 0 immediately; after release, FIFO is empty and clk_symbol first pulses 128 clocks later.
- MOD_UNDERRUN_CNT_EN defined, 3 idle periods -> underrun_cnt=3. Then pulse underrun_clr on a boundary cycle while underrunning -> underrun_cnt=0.
